// File: rtl/vadd_float_axi_pkg.sv
// vadd_float_axi_pkg: shared FSM state types and default geometry for the AXI memory responder
package vadd_float_axi_pkg;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  localparam int C_ADDR_WIDTH_DEF = 64;
  localparam int C_DATA_WIDTH_DEF = 512;
  localparam int C_MEM_DEPTH_DEF = 1024;
  localparam int C_BYTES = C_DATA_WIDTH_DEF / 8;
  localparam int C_OFF_W = $clog2(C_BYTES);
  localparam int C_IDX_W = $clog2(C_MEM_DEPTH_DEF);
endpackage

// File: rtl/vadd_float_mem_sdp.sv
// vadd_float_mem_sdp: simple dual-port RAM, byte-enable write port, registered read-first read port
module vadd_float_mem_sdp #(
  parameter int DW = 512,
  parameter int AW = 10
) (
  input  logic            ap_clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge ap_clk) begin
    if (re) rdata <= mem[raddr];
    for (int b = 0; b < DW / 8; b++)
      if (we && wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
  end
endmodule

// File: rtl/vadd_float_axi_mem_responder.sv
// vadd_float_axi_mem_responder: AXI4 INCR-burst responder backed by on-chip memory
module vadd_float_axi_mem_responder
  import vadd_float_axi_pkg::*;
#(
  parameter int C_ADDR_WIDTH = C_ADDR_WIDTH_DEF,
  parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
  parameter int C_MEM_DEPTH_WORDS = C_MEM_DEPTH_DEF
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                      s_axi_rlast,
  output logic [15:0]               wlast_err_cnt
);
  localparam int ow = $clog2(C_DATA_WIDTH / 8);
  localparam int iw = $clog2(C_MEM_DEPTH_WORDS);
  wr_state_t wr_state;
  rd_state_t rd_state;
  logic [iw-1:0] wr_idx, rd_idx;
  logic [7:0] wr_left, rd_left;
  logic rd_more, pend, pend_last, sv, slast;
  logic [C_DATA_WIDTH-1:0] mem_q, sdata;
  logic aw_hs, w_hs, ar_hs, pop, rd_en, unused_addr;
  logic [1:0] occ;
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};
  always_comb begin
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs = s_axi_wvalid && s_axi_wready;
    ar_hs = s_axi_arvalid && s_axi_arready;
    pop = s_axi_rvalid && s_axi_rready;
    occ = 2'(s_axi_rvalid) + 2'(sv) + 2'(pend) - 2'(pop);
    rd_en = rd_state == RD_DATA && rd_more && occ < 2'd2;
  end
  vadd_float_mem_sdp #(.DW(C_DATA_WIDTH), .AW(iw)) u_mem (
    .ap_clk(ap_clk),
    .we(w_hs),
    .waddr(wr_idx),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .re(rd_en),
    .raddr(rd_idx),
    .rdata(mem_q)
  );
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_state <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      wlast_err_cnt <= 16'd0;
      wr_idx <= '0;
      wr_left <= 8'd0;
    end else begin
      if (w_hs && (s_axi_wlast != (wr_left == 8'd0)) && wlast_err_cnt != 16'hFFFF)
        wlast_err_cnt <= wlast_err_cnt + 16'd1;
      case (wr_state)
        WR_IDLE: begin
          s_axi_awready <= 1'b1;
          if (aw_hs) begin
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b1;
            wr_idx <= s_axi_awaddr[ow +: iw];
            wr_left <= s_axi_awlen;
            wr_state <= WR_DATA;
          end
        end
        WR_DATA: if (w_hs) begin
          wr_idx <= wr_idx + 1'b1;
          wr_left <= wr_left - 8'd1;
          if (wr_left == 8'd0) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            wr_state <= WR_RESP;
          end
        end
        WR_RESP: if (s_axi_bready) begin
          s_axi_bvalid <= 1'b0;
          s_axi_awready <= 1'b1;
          wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end
  // Output register plus one skid entry form the 2-deep FIFO; reads are issued only against free credit
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rd_state <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast <= 1'b0;
      s_axi_rdata <= '0;
      rd_idx <= '0;
      rd_left <= 8'd0;
      rd_more <= 1'b0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      sv <= 1'b0;
      slast <= 1'b0;
      sdata <= '0;
    end else begin
      pend <= rd_en;
      if (rd_en) begin
        rd_idx <= rd_idx + 1'b1;
        rd_left <= rd_left - 8'd1;
        rd_more <= rd_left != 8'd0;
        pend_last <= rd_left == 8'd0;
      end
      case (rd_state)
        RD_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            rd_idx <= s_axi_araddr[ow +: iw];
            rd_left <= s_axi_arlen;
            rd_more <= 1'b1;
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: if (pop && s_axi_rlast) begin
          s_axi_arready <= 1'b1;
          rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
      if (!s_axi_rvalid || pop) begin
        s_axi_rvalid <= sv || pend;
        s_axi_rdata <= sv ? sdata : pend ? mem_q : s_axi_rdata;
        s_axi_rlast <= sv ? slast : pend && pend_last;
        sv <= sv && pend;
        sdata <= mem_q;
        slast <= pend_last;
      end else if (pend) begin
        sv <= 1'b1;
        sdata <= mem_q;
        slast <= pend_last;
      end
    end
  end
endmodule

// File: tb/tb_vadd_float_axi_mem_responder.sv
// tb_vadd_float_axi_mem_responder: directed self-checking bench for the AXI memory responder
module tb_vadd_float_axi_mem_responder;
  logic ap_clk = 0, ap_rst_n = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [63:0] awaddr = 0, araddr = 0, wstrb = 0;
  logic [7:0] awlen = 0, arlen = 0;
  logic [511:0] wdata = 0, rdata;
  logic [15:0] err_cnt;
  logic [511:0] rd_buf [0:255];
  logic rl_buf [0:255];
  int vecs = 0, errs = 0;

  always #5 ap_clk = ~ap_clk;

  vadd_float_axi_mem_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .wlast_err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [511:0] base,
                           input logic [63:0] strb, input int wl_beat, input int bhold,
                           output int b_lat, output bit aw_low, output bit ok);
    int t;
    ok = 1; aw_low = 1;
    awaddr = addr; awlen = len; awvalid = 1; t = 0;
    while (!awready && t < 50) begin tick(); t++; end
    if (t >= 50) ok = 0;
    tick();
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = base + 512'(i); wstrb = strb;
      wlast = (wl_beat < 0) ? (i == int'(len)) : (i == wl_beat);
      t = 0;
      while (!wready && t < 50) begin tick(); t++; end
      if (t >= 50) ok = 0;
      tick();
    end
    wvalid = 0; wlast = 0;
    b_lat = 0;
    while (!bvalid && b_lat < 50) begin tick(); b_lat++; end
    if (b_lat >= 50) ok = 0;
    for (int k = 0; k < bhold; k++) begin
      if (awready || !bvalid) aw_low = 0;
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] rpat,
                          output int r_lat, output int nb, output int ncyc, output bit stable, output bit ok);
    int t;
    logic hold_v;
    logic [511:0] hold_d;
    logic hold_l;
    ok = 1; stable = 1; nb = 0; ncyc = 0; hold_v = 0; hold_d = 0; hold_l = 0;
    araddr = addr; arlen = len; arvalid = 1; t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    if (t >= 50) ok = 0;
    tick();
    arvalid = 0;
    r_lat = 0;
    while (!rvalid && r_lat < 50) begin tick(); r_lat++; end
    if (r_lat >= 50) ok = 0;
    while (nb <= int'(len) && ncyc < 2000) begin
      rready = rpat[ncyc % 4];
      if (hold_v && (!rvalid || rdata !== hold_d || rlast !== hold_l)) stable = 0;
      hold_v = rvalid && !rready; hold_d = rdata; hold_l = rlast;
      if (rvalid && rready) begin rd_buf[nb] = rdata; rl_buf[nb] = rlast; nb++; end
      ncyc++;
      tick();
    end
    rready = 0;
    if (ncyc >= 2000) ok = 0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vecs++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, rdata, err_cnt} !== '0) begin
      errs++; $display("FAIL reset_values got aw=%b ar=%b w=%b b=%b rv=%b rl=%b rd=%0h err=%0d want all 0",
                       awready, arready, wready, bvalid, rvalid, rlast, rdata, err_cnt);
    end
    ap_rst_n = 1;
    tick();
    vecs++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errs++; $display("FAIL ready_after_reset got aw=%b ar=%b want 1 1", awready, arready);
    end
  endtask

  task automatic test_burst();
    int bl, rl, nb, nc; bit awl, ok, st;
    axi_write(64'h0, 8'd3, 512'hA0, '1, -1, 0, bl, awl, ok);
    vecs++;
    if (!ok || bl !== 0) begin errs++; $display("FAIL burst_bresp got ok=%b lat=%0d want 1 0", ok, bl); end
    axi_read(64'h0, 8'd3, 4'hF, rl, nb, nc, st, ok);
    vecs++;
    if (!ok || rl !== 2 || nb !== 4 || nc !== 4) begin
      errs++; $display("FAIL burst_read_timing got ok=%b lat=%0d beats=%0d cyc=%0d want 1 2 4 4", ok, rl, nb, nc);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (rd_buf[i] !== 512'hA0 + 512'(i) || rl_buf[i] !== (i == 3)) begin
        errs++; $display("FAIL burst_beat%0d got %0h last=%b want %0h last=%b", i, rd_buf[i], rl_buf[i], 512'hA0 + 512'(i), i == 3);
      end
    end
    vecs++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errs++; $display("FAIL burst_idle got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_strobe();
    int bl, rl, nb, nc; bit awl, ok, st;
    logic [511:0] exp;
    exp = '1; exp[31:0] = 32'h0;
    axi_write(64'd320, 8'd0, '1, '1, -1, 0, bl, awl, ok);
    axi_write(64'd320, 8'd0, '0, 64'h000F, -1, 0, bl, awl, ok);
    axi_read(64'd320, 8'd0, 4'hF, rl, nb, nc, st, ok);
    vecs++;
    if (!ok || nb !== 1 || rd_buf[0] !== exp || rl_buf[0] !== 1'b1) begin
      errs++; $display("FAIL strobe got ok=%b beats=%0d data=%0h want 1 1 %0h", ok, nb, rd_buf[0], exp);
    end
  endtask

  task automatic test_stall();
    int bl, rl, nb, nc; bit awl, ok, st;
    axi_write(64'd1024, 8'd15, 512'h1000, '1, -1, 0, bl, awl, ok);
    axi_read(64'd1024, 8'd15, 4'b1001, rl, nb, nc, st, ok);
    vecs++;
    if (!ok || nb !== 16 || !st) begin
      errs++; $display("FAIL stall_flow got ok=%b beats=%0d stable=%b want 1 16 1", ok, nb, st);
    end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (rd_buf[i] !== 512'h1000 + 512'(i) || rl_buf[i] !== (i == 15)) begin
        errs++; $display("FAIL stall_beat%0d got %0h last=%b want %0h", i, rd_buf[i], rl_buf[i], 512'h1000 + 512'(i));
      end
    end
    vecs++;
    if (rvalid !== 1'b0) begin errs++; $display("FAIL stall_extra_beat got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_wrap();
    int bl, rl, nb, nc; bit awl, ok, st;
    axi_write(64'd65472, 8'd1, 512'hB0, '1, -1, 0, bl, awl, ok);
    axi_read(64'h0, 8'd0, 4'hF, rl, nb, nc, st, ok);
    vecs++;
    if (rd_buf[0] !== 512'hB1) begin errs++; $display("FAIL wrap_word0 got %0h want b1", rd_buf[0]); end
    axi_read(64'd65472, 8'd1, 4'hF, rl, nb, nc, st, ok);
    vecs++;
    if (nb !== 2 || rd_buf[0] !== 512'hB0 || rd_buf[1] !== 512'hB1) begin
      errs++; $display("FAIL wrap_read got beats=%0d %0h %0h want 2 b0 b1", nb, rd_buf[0], rd_buf[1]);
    end
  endtask

  task automatic test_concurrent();
    int bl, rl, nb, nc; bit awl, okw, okr, st;
    axi_write(64'h0, 8'd7, 512'hC0, '1, -1, 0, bl, awl, okw);
    fork
      axi_write(64'd6400, 8'd7, 512'hD0, '1, -1, 5, bl, awl, okw);
      axi_read(64'h0, 8'd7, 4'hF, rl, nb, nc, st, okr);
    join
    vecs++;
    if (!okw || !awl) begin errs++; $display("FAIL conc_bhold got ok=%b held=%b want 1 1", okw, awl); end
    vecs++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errs++; $display("FAIL conc_after_b got bvalid=%b awready=%b want 0 1", bvalid, awready);
    end
    vecs++;
    if (!okr || nb !== 8 || rl !== 2) begin errs++; $display("FAIL conc_read got ok=%b beats=%0d lat=%0d want 1 8 2", okr, nb, rl); end
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (rd_buf[i] !== 512'hC0 + 512'(i)) begin
        errs++; $display("FAIL conc_rbeat%0d got %0h want %0h", i, rd_buf[i], 512'hC0 + 512'(i));
      end
    end
    axi_read(64'd6400, 8'd7, 4'hF, rl, nb, nc, st, okr);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (rd_buf[i] !== 512'hD0 + 512'(i)) begin
        errs++; $display("FAIL conc_wbeat%0d got %0h want %0h", i, rd_buf[i], 512'hD0 + 512'(i));
      end
    end
  endtask

  task automatic test_wlast();
    int bl, rl, nb, nc; bit awl, ok, st;
    axi_write(64'd12800, 8'd3, 512'hE0, '1, 1, 0, bl, awl, ok);
    vecs++;
    if (!ok || err_cnt !== 16'd2) begin errs++; $display("FAIL wlast_err got ok=%b cnt=%0d want 1 2", ok, err_cnt); end
    axi_read(64'd12800, 8'd3, 4'hF, rl, nb, nc, st, ok);
    vecs++;
    if (nb !== 4 || rd_buf[0] !== 512'hE0 || rd_buf[3] !== 512'hE3) begin
      errs++; $display("FAIL wlast_burst got beats=%0d %0h %0h want 4 e0 e3", nb, rd_buf[0], rd_buf[3]);
    end
  endtask

  task automatic test_reset_mid();
    int t, seen, rl, nb, nc; bit ok, st;
    araddr = 0; arlen = 8'd7; arvalid = 1; t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    tick();
    arvalid = 0; rready = 1; seen = 0; t = 0;
    while (seen < 3 && t < 50) begin if (rvalid) seen++; t++; tick(); end
    vecs++;
    if (rvalid !== 1'b1 || rdata !== 512'hC3) begin
      errs++; $display("FAIL mid_beat3 got rvalid=%b data=%0h want 1 c3", rvalid, rdata);
    end
    ap_rst_n = 0; rready = 0;
    tick();
    vecs++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || err_cnt !== 16'd0) begin
      errs++; $display("FAIL mid_in_reset got rvalid=%b arready=%b err=%0d want 0 0 0", rvalid, arready, err_cnt);
    end
    ap_rst_n = 1;
    tick();
    vecs++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errs++; $display("FAIL mid_release got arready=%b rvalid=%b want 1 0", arready, rvalid);
    end
    axi_read(64'h0, 8'd1, 4'hF, rl, nb, nc, st, ok);
    vecs++;
    if (!ok || nb !== 2 || rd_buf[0] !== 512'hC0 || rd_buf[1] !== 512'hC1 || rl_buf[1] !== 1'b1) begin
      errs++; $display("FAIL mid_reread got ok=%b beats=%0d %0h %0h want 1 2 c0 c1", ok, nb, rd_buf[0], rd_buf[1]);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_strobe();
    test_stall();
    test_wrap();
    test_concurrent();
    test_wlast();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
